// File: rtl/sram_port_initiator.sv
// rtl/sram_port_initiator.sv - request initiator for one dual-port SRAM port with 2-entry response buffer
// Define SRAM_RMW_EN to emulate partial byte-enable writes by read-modify-write.
module sram_port_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic [ADDR_BITS-1:0]    req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    sram_en_o,
  output logic                    sram_we_o,
  output logic [ADDR_BITS-1:0]    sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]            count;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  pop;
  logic                  push;
  logic                  accept;
  logic                  space;
  logic [2:0]            occ;

  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = inflight;
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_valid_o = (count != 2'd0);
  assign rsp_data_o  = buf_q[rd_ptr];

  // Reads already launched count against buffer space so a push can never overflow.
  assign occ   = {1'b0, count} + {2'b00, inflight};
  assign space = (occ < (3'd2 + {2'b00, pop}));

`ifdef SRAM_RMW_EN
  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state;
  state_t                state_n;
  logic                  partial;
  logic [ADDR_BITS-1:0]  rmw_addr;
  logic [BE_W-1:0]       rmw_be;
  logic [DATA_WIDTH-1:0] rmw_wdata;
  logic [DATA_WIDTH-1:0] rmw_merged;

  assign partial     = req_we_i & ~(&req_be_i);
  // The RMW read slot shares sram_rdata_i, so a partial write waits out any read in flight.
  assign req_ready_o = ~rst_i & (state == IDLE) & space & ~(partial & inflight);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rmw_addr  <= '0;
      rmw_be    <= '0;
      rmw_wdata <= '0;
    end else begin
      state <= state_n;
      if (accept && partial) begin
        rmw_addr  <= req_addr_i;
        rmw_be    <= req_be_i;
        rmw_wdata <= req_wdata_i;
      end
    end
  end

  always_comb begin
    rmw_merged = sram_rdata_i;
    for (int i = 0; i < BE_W; i++) begin
      if (rmw_be[i]) rmw_merged[8*i +: 8] = rmw_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_n      = state;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    case (state)
      IDLE: begin
        if (accept) begin
          sram_en_o = 1'b1;
          sram_we_o = req_we_i & ~partial;
          if (partial) state_n = RMW_WR;
        end
      end
      RMW_WR: begin
        sram_en_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = rmw_addr;
        sram_wdata_o = rmw_merged;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
`else
  logic unused_be;

  assign unused_be   = ^req_be_i;
  assign req_ready_o = ~rst_i & space;

  always_comb begin
    sram_en_o    = accept;
    sram_we_o    = accept & req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      inflight <= accept & ~req_we_i;
      if (push) begin
        buf_q[wr_ptr] <= sram_rdata_i;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sram_port_initiator.sv
// tb/tb_sram_port_initiator.sv - scoreboard bench for sram_port_initiator with behavioural SRAM
module tb_sram_port_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_be_i = 4'h0;
  logic [15:0] req_addr_i = 16'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic        sram_en_o;
  logic        sram_we_o;
  logic [15:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [31:0] pre_data = 32'h0;
  logic [31:0] mem [0:65535];

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  sram_port_initiator #(.DATA_WIDTH(32), .ADDR_BITS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_en_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else sram_rdata_i <= mem[sram_addr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data_o, e.data);
          if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk_i); #1;
    pre_we = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge with valid dropped.
  task automatic issue(input logic we, input logic [3:0] be, input logic [15:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input int lat,
                       output int acc);
    int n;
    exp_t e;
    req_valid_i = 1'b1; req_we_i = we; req_be_i = be; req_addr_i = a; req_wdata_i = wd;
    n = 0;
    acc = -1;
    while (n < 50) begin
      @(negedge clk_i);
      if (req_ready_o) break;
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      acc = cyc;
      if (!we) begin
        e.data = exp_d;
        e.cyc  = (lat > 0) ? acc + lat : -1;
        exp_q.push_back(e);
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int a0, a1, a2, a3;
    logic [31:0] rmw_exp;
    logic [31:0] rst_exp;
    logic [31:0] rdy_exp;

`ifdef SRAM_RMW_EN
    rmw_exp = 32'h11BB33DD;
    rst_exp = 32'hCAFEF00D;
    rdy_exp = 32'd0;
`else
    rmw_exp = 32'hAABBCCDD;
    rst_exp = 32'h12345678;
    rdy_exp = 32'd1;
`endif

    @(posedge clk_i); #1;
    preload(16'h0010, 32'hDEADBEEF);
    preload(16'h0001, 32'h0000_1111);
    preload(16'h0002, 32'h0000_2222);
    preload(16'h0003, 32'h0000_3333);
    preload(16'h0004, 32'h0000_4444);
    preload(16'h0020, 32'h11223344);
    preload(16'h0030, 32'hCAFEF00D);
    preload(16'h0005, 32'h55AA55AA);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 32'd0);
    chk("rst_rsp_valid", rsp_valid_o, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_sram_en", sram_en_o, 32'd0);
    chk("rst_sram_we", sram_we_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", req_ready_o, 32'd1);
    chk("post_rst_valid", rsp_valid_o, 32'd0);
    @(posedge clk_i); #1;

    // Single read with exact two-cycle latency.
    issue(1'b0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 2, a0);
    drain();

    // Back-to-back reads: one accept per cycle, responses on consecutive cycles.
    issue(1'b0, 4'h0, 16'h0001, 32'h0, 32'h0000_1111, 2, a0);
    issue(1'b0, 4'h0, 16'h0002, 32'h0, 32'h0000_2222, 2, a1);
    issue(1'b0, 4'h0, 16'h0003, 32'h0, 32'h0000_3333, 2, a2);
    issue(1'b0, 4'h0, 16'h0004, 32'h0, 32'h0000_4444, 2, a3);
    chk("b2b_accept_span", a3 - a0, 32'd3);
    drain();

    // Back-pressure: third read held off until a pop.
    rsp_ready_i = 1'b0;
    issue(1'b0, 4'h0, 16'h0002, 32'h0, 32'h0000_2222, 0, a0);
    issue(1'b0, 4'h0, 16'h0003, 32'h0, 32'h0000_3333, 0, a1);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h0004;
    @(negedge clk_i);
    chk("bp_ready_low_0", req_ready_o, 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("bp_ready_low_1", req_ready_o, 32'd0);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    issue(1'b0, 4'h0, 16'h0004, 32'h0, 32'h0000_4444, 0, a2);
    drain();

    // Partial write: RMW merge with macro, plain full write without.
    issue(1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD, 32'h0, 0, a0);
    @(negedge clk_i);
    chk("rmw_ready_gap", req_ready_o, rdy_exp);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rmw_ready_back", req_ready_o, 32'd1);
    @(posedge clk_i); #1;
    issue(1'b0, 4'h0, 16'h0020, 32'h0, rmw_exp, 2, a0);
    drain();

    // Reset landing in the RMW write cycle must abandon the write.
    issue(1'b1, 4'b0011, 16'h0030, 32'h12345678, 32'h0, 0, a0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rmw_sram_en", sram_en_o, 32'd0);
    chk("rst_rmw_valid", rsp_valid_o, 32'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_rmw_ready", req_ready_o, 32'd1);
    chk("rst_rmw_valid2", rsp_valid_o, 32'd0);
    @(posedge clk_i); #1;
    issue(1'b0, 4'h0, 16'h0030, 32'h0, rst_exp, 2, a0);
    drain();

    // Read then immediate full write to the same word.
    issue(1'b0, 4'h0, 16'h0005, 32'h0, 32'h55AA55AA, 2, a0);
    issue(1'b1, 4'hF, 16'h0005, 32'h0, 32'h0, 0, a1);
    issue(1'b0, 4'h0, 16'h0005, 32'h0, 32'h0, 2, a2);
    chk("rw_accept_span", a2 - a0, 32'd2);
    drain();

    repeat (3) @(posedge clk_i);
    chk("final_valid", rsp_valid_o, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d errors=%0d", tests, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_initiator.md
# sram_port_initiator

Request-side initiator for one port of the dual-port SRAM in the Aquila memory subsystem. Accepts valid/ready read and write requests from a core-side client, drives the SRAM port's enable/write/address/data pins, and absorbs the SRAM's fixed one-cycle read latency in a 2-entry response buffer so the client can apply back-pressure. Optionally emulates byte-enable writes on the word-only SRAM by read-modify-write.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must equal the attached SRAM's RAM_WIDTH; multiple of 8.
- ADDR_BITS, 16, word address width; must equal the SRAM's RAM_ADDR_BITS.

Ports:
- clk_i  in  1  single clock; the attached SRAM port is clocked by the same clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
- req_we_i  in  1  1 = write, 0 = read.
- req_be_i  in  DATA_WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
- req_addr_i  in  ADDR_BITS  word address.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  read data available.
- rsp_ready_i  in  1  client consumes response when rsp_valid_o & rsp_ready_i.
- rsp_data_o  out  DATA_WIDTH  read data, head of the response buffer.
- sram_en_o  out  1  SRAM port enable.
- sram_we_o  out  1  SRAM port write enable.
- sram_addr_o  out  ADDR_BITS  SRAM port address.
- sram_wdata_o  out  DATA_WIDTH  SRAM port write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM port read data; valid the cycle after a read is issued.

## Operation
- State machine: IDLE, RMW_WR (RMW_WR exists only with SRAM_RMW_EN).
- Counters: inflight (0/1), reads issued last cycle; count (0..2), response buffer occupancy.
- SRAM pins are combinational from the accepted request (IDLE) or from the held RMW registers (RMW_WR).
- Read accepted in IDLE: sram_en_o=1, sram_we_o=0, sram_addr_o=req_addr_i; inflight set; next cycle sram_rdata_i is pushed into the buffer.
- Full write (all req_be_i ones, or macro absent): sram_en_o=1, sram_we_o=1, addr/wdata from request, single cycle; no response generated.
- req_ready_o = ~rst_i & state==IDLE & (count + inflight - pop < 2), where pop = rsp_valid_o & rsp_ready_i. Buffer can never overflow.
- Response buffer: FIFO, rsp_valid_o = count!=0; simultaneous push and pop keeps count and preserves order.
- Responses return strictly in request order; writes issued after a read do not disturb that read's data (read data already launched).
- No request: sram_en_o=0, sram_we_o=0; addr/wdata don't-care (drive request inputs).

## Timing
- Reset values (while rst_i high and immediately after): req_ready_o=0 during reset, rsp_valid_o=0, rsp_data_o=0, sram_en_o=0, sram_we_o=0, state IDLE, count=0, inflight=0.
- Read latency: accept at cycle N -> rsp_valid_o at cycle N+2 earliest.
- Throughput: one read per cycle sustained while rsp_ready_i stays high; full writes one per cycle.
- rsp_ready_i low: after buffer and inflight total 2, req_ready_o drops until a pop.
- Reset mid-operation: buffer and inflight cleared; SRAM data returning after reset discarded; RMW in progress abandoned with no SRAM write.

## Configuration
- SRAM_RMW_EN defined: write with partial req_be_i accepted in IDLE issues SRAM read of req_addr_i (sram_we_o=0), latches addr/be/wdata, moves to RMW_WR with req_ready_o=0; in RMW_WR drives sram_en_o=1, sram_we_o=1, sram_wdata_o = per-byte mux(be ? latched wdata : sram_rdata_i), returns to IDLE. 2 cycles, no response, RMW read data never enters the buffer. Partial write accepted only when inflight=0.
- Not defined: req_be_i ignored, every write is a full-word single-cycle write, RMW_WR state and latches absent.

## Test plan
- Reset then read addr 0x0010 holding 0xDEADBEEF, rsp_ready_i=1 -> rsp_valid_o=1 with 0xDEADBEEF exactly 2 cycles after accept; all outputs 0 during reset.
- Back-to-back reads 0x1,0x2,0x3,0x4 with rsp_ready_i=1 -> 4 accepts in 4 cycles, responses in order on consecutive cycles.
- rsp_ready_i=0, issue 3 reads -> first two accepted, req_ready_o=0 on third; raise rsp_ready_i -> third accepted, order intact, no data lost.
- SRAM_RMW_EN: word 0x11223344 at 0x20, write be=4'b0101 data 0xAABBCCDD -> req_ready_o low one cycle, readback 0x11BB33DD; without macro readback 0xAABBCCDD.
- Assert rst_i during RMW_WR -> no SRAM write (word unchanged), rsp_valid_o=0, state IDLE after release.
- Read 0x5 then immediate full write 0x5=0x0 -> read response returns old value, subsequent read returns 0x0.
